// File: rtl/mor1kx_sync_fifo_fwft.sv
// First-word-fall-through FIFO over a 1-cycle registered-read dual-port RAM plus an output stage.
// Optional almost_full output enabled by defining MOR1KX_FIFO_ALMOST_FULL_EN.
module mor1kx_sync_fifo_fwft #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int AF_MARGIN   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DEPTH_WIDTH:0]  level
`ifdef MOR1KX_FIFO_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [DEPTH_WIDTH:0]  wr_ptr;
  logic [DEPTH_WIDTH:0]  rd_ptr;
  logic [DEPTH_WIDTH:0]  ram_cnt;
  logic                  out_valid;
  logic                  push;
  logic                  pop;
  logic                  re;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointer MSB separates full from empty when the RAM indices coincide.
  assign ram_cnt = wr_ptr - rd_ptr;

  assign wr_ready = (ram_cnt != (DEPTH_WIDTH+1)'(DEPTH)) && !flush;
  assign push     = wr_valid && wr_ready;
  assign pop      = out_valid && rd_ready;
  assign re       = (ram_cnt != '0) && (!out_valid || pop) && !flush;

  assign rd_valid = out_valid;
  assign level    = ram_cnt + {{DEPTH_WIDTH{1'b0}}, out_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (re) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  // RAM and its read register carry no reset; rd_data is only meaningful with rd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
    end
    if (re) begin
      rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
    end
  end

`ifdef MOR1KX_FIFO_ALMOST_FULL_EN
  logic [DEPTH_WIDTH+1:0] free_slots;

  assign free_slots  = (DEPTH_WIDTH+2)'(DEPTH + 1) - {1'b0, level};
  assign almost_full = free_slots <= (DEPTH_WIDTH+2)'(AF_MARGIN);
`endif

endmodule

// File: tb/tb_mor1kx_sync_fifo_fwft.sv
// Scoreboard bench for mor1kx_sync_fifo_fwft (DEPTH_WIDTH=2, capacity 5).
module tb_mor1kx_sync_fifo_fwft;

  localparam int DW = 2;

  typedef enum logic [2:0] {K_LEVEL, K_RVLD, K_WRDY, K_RDATA, K_AF, K_QEMPTY, K_RECV} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic [31:0] val;
  } chk_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [31:0]   wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [31:0]   rd_data;
  logic [DW:0]   level;
`ifdef MOR1KX_FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  mor1kx_sync_fifo_fwft #(.DEPTH_WIDTH(DW), .DATA_WIDTH(32), .AF_MARGIN(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .level(level)
`ifdef MOR1KX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q [$];
  chk_t        chk_q [$];
  int          chk_idx = 0;
  int          n_cmp   = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  logic [31:0] act;
  logic [31:0] want;

  // Monitor: evaluates queued expectations and scores every handshake on the falling edge.
  always @(negedge clk) begin
    while (chk_idx < chk_q.size()) begin
      act = 32'h0;
      case (chk_q[chk_idx].kind)
        K_LEVEL:  act = 32'(level);
        K_RVLD:   act = 32'(rd_valid);
        K_WRDY:   act = 32'(wr_ready);
        K_RDATA:  act = rd_data;
`ifdef MOR1KX_FIFO_ALMOST_FULL_EN
        K_AF:     act = 32'(almost_full);
`endif
        K_QEMPTY: act = 32'(exp_q.size());
        K_RECV:   act = 32'(n_pops);
        default:  act = 32'hFFFF_FFFF;
      endcase
      n_cmp++;
      if (act !== chk_q[chk_idx].val) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h", chk_q[chk_idx].kind.name(), act, chk_q[chk_idx].val);
      end
      chk_idx++;
    end
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (rd_valid && rd_ready) begin
        n_cmp++;
        n_pops++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_data: got %h, want no output (scoreboard empty)", rd_data);
        end else begin
          want = exp_q.pop_front();
          if (rd_data !== want) begin
            n_fail++;
            $display("FAIL pop_data: got %h, want %h", rd_data, want);
          end
        end
      end
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
    end
  end

  task automatic expect_val(input kind_t k, input logic [31:0] v);
    chk_t c;
    c.kind = k;
    c.val  = v;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    rd_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int          idx;
    int          base;
    logic        af_exp;
    rst_n    = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (2) step();
    expect_val(K_RVLD, 0);
    expect_val(K_WRDY, 1);
    expect_val(K_LEVEL, 0);
`ifdef MOR1KX_FIFO_ALMOST_FULL_EN
    expect_val(K_AF, 0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // 1: single word latency through an empty FIFO
    wr_valid = 1'b1;
    wr_data  = 32'hA5A5_A5A5;
    rd_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    expect_val(K_LEVEL, 1);
    expect_val(K_RVLD, 0);
    step();
    expect_val(K_RVLD, 1);
    expect_val(K_RDATA, 32'hA5A5_A5A5);
    expect_val(K_LEVEL, 1);
    step();
    expect_val(K_RVLD, 0);
    expect_val(K_LEVEL, 0);
    rd_ready = 1'b0;
    step();

    // 2: fill to capacity, sixth offer refused, then drain back to back
    for (int i = 1; i <= 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(i);
      step();
      expect_val(K_LEVEL, (i < 5) ? 32'(i) : 32'd5);
      expect_val(K_WRDY, (i < 5) ? 32'd1 : 32'd0);
      af_exp = (i >= 3);
`ifdef MOR1KX_FIFO_ALMOST_FULL_EN
      expect_val(K_AF, 32'(af_exp));
`endif
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      expect_val(K_RVLD, 1);
      expect_val(K_RDATA, 32'(k));
      step();
    end
    expect_val(K_RVLD, 0);
    expect_val(K_LEVEL, 0);
    expect_val(K_QEMPTY, 0);
    step();

    // 3: steady push+pop at level 3
    fill(32'h30, 3);
    expect_val(K_LEVEL, 3);
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h33 + 32'(i);
      rd_ready = 1'b1;
      step();
      expect_val(K_LEVEL, 3);
      expect_val(K_RVLD, 1);
    end
    wr_valid = 1'b0;
    repeat (3) step();
    expect_val(K_RVLD, 0);
    expect_val(K_LEVEL, 0);
    rd_ready = 1'b0;
    step();

    // 4: random-handshake stream of 20 words
    base = n_pops;
    idx  = 0;
    for (int cyc = 0; cyc < 2000 && (n_pops - base) < 20; cyc++) begin
      wr_valid = (idx < 20) && ($urandom_range(0, 2) != 0);
      wr_data  = 32'h100 + 32'(idx);
      rd_ready = ($urandom_range(0, 2) != 0);
      if (wr_valid && wr_ready) idx++;
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    expect_val(K_RECV, 32'(base + 20));
    expect_val(K_QEMPTY, 0);
    expect_val(K_LEVEL, 0);
    expect_val(K_RVLD, 0);
    step();

    // 5: flush at level 4 discards the concurrent push and pop
    fill(32'h50, 4);
    expect_val(K_LEVEL, 4);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    rd_ready = 1'b1;
    expect_val(K_WRDY, 0);
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    expect_val(K_LEVEL, 0);
    expect_val(K_RVLD, 0);
    step();
    wr_valid = 1'b1;
    wr_data  = 32'h77;
    step();
    wr_valid = 1'b0;
    step();
    expect_val(K_RVLD, 1);
    expect_val(K_RDATA, 32'h77);
    step();
    expect_val(K_RVLD, 0);
    expect_val(K_QEMPTY, 0);
    step();

    // 6: asynchronous reset between edges, mid-transfer
    fill(32'h60, 3);
    wr_valid = 1'b1;
    wr_data  = 32'h63;
    rd_ready = 1'b1;
    #1;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    expect_val(K_RVLD, 0);
    expect_val(K_LEVEL, 0);
    expect_val(K_WRDY, 1);
    #5;
    rst_n = 1'b1;
    step();
    wr_valid = 1'b1;
    wr_data  = 32'h55;
    rd_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    step();
    expect_val(K_RVLD, 1);
    expect_val(K_RDATA, 32'h55);
    step();
    expect_val(K_LEVEL, 0);
    expect_val(K_QEMPTY, 0);
    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
